hilo_muldiv_sequencer: RTL and testbench
========================================

Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide engine and sequencer that owns all writes to the HI/LO register pair.
- Accepts an issue from the EX stage and runs a 32-iteration shift-add multiply or restoring divide, then drives the HI_Reg/LO_Reg load enables.
- Generates the stall that freezes PC, IF/ID and ID/EX (their Ld inputs) while a result is pending.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Rst, input, 1, asynchronous, active-low reset.
- Start, input, 1, EX-stage mul/div instruction valid.
- Op, input, 3, operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 110/111 ignored.
- OpA, input, 32, rs operand / dividend.
- OpB, input, 32, rt operand / divisor.
- HiIn, input, 32, current HI_out, used as accumulate base.
- LoIn, input, 32, current LO_out, used as accumulate base.
- HiLoRead, input, 1, an mfhi/mflo is in ID or EX.
- Busy, output, 1, operation in flight.
- Stall, output, 1, pipeline hold; drives Ld low.
- Done, output, 1, single-cycle pulse in the WRITE state.
- DivByZero, output, 1, valid with Done.
- HiOut, output, 32, result to HI_Reg.
- LoOut, output, 32, result to LO_Reg.
- HiLoWrite, output, 2, bit0 = HI load, bit1 = LO load; same encoding as the existing HiLoWrite.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE, counter 0. Busy, Stall, Done, DivByZero, HiLoWrite, HiOut and LoOut all 0. Reset mid-operation aborts with no HI/LO write.
- States: IDLE, ITER, FIX, ACC, WRITE.
- IDLE:
  - Start with a legal Op is accepted on the clock edge (cycle 0). The edge latches |OpA| and |OpB| (magnitudes for signed ops, raw for unsigned), both operand signs, the Op, HiIn and LoIn.
  - Start with Op 110/111 is ignored.
  - DIV/DIVU with OpB==0 goes straight to WRITE, skipping iteration.
- ITER, cycles 1..32, 6-bit counter:
  - Multiply: 64-bit product register; add multiplicand if LSB set, then shift right.
  - Divide: restoring step on the {remainder, quotient} register.
  - Exit to FIX after the 32nd iteration.
- FIX, cycle 33:
  - Multiply: negate the 64-bit product if sign(OpA)^sign(OpB), signed ops only.
  - Divide: quotient sign = sA^sB; remainder sign = sA.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0 (no trap).
  - Next state is ACC for MADD/MSUB, otherwise WRITE.
- ACC, cycle 34: {Hi,Lo} = {HiIn,LoIn} ± product, 64-bit wrap-around, carry propagates LO→HI.
- WRITE (cycle 34, or 35 for MADD/MSUB, or 1 for divide-by-zero):
  - HiLoWrite=2'b11, Done=1, HiOut/LoOut valid.
  - HI/LO registers load at the end of this cycle.
  - Next state is IDLE.
- Divide-by-zero result: HI=OpA (raw), LO=DIV0_LO, DivByZero=1.
- Busy = (state != IDLE).
- Stall = Busy & (Start | HiLoRead), combinational.
  - WRITE is included, so a reader never sees stale HI/LO.
  - A Start seen while Busy is not accepted; the held instruction re-presents and is accepted in the first IDLE cycle.
- HiOut/LoOut hold their last value outside WRITE; HiLoWrite is 0 outside WRITE.

Decomposition:
- Shared package muldiv_pkg: Op encodings (OP_MULT..OP_MSUB), state encodings, ITER_COUNT=32, HiLoWrite bit positions.
- One sub-module, muldiv_core: 64-bit working register, 33-bit add/subtract, per-iteration step and sign-fix logic.
- The FSM, counter, stall and accumulate control stay in hilo_muldiv_sequencer.

Test Plan:
- MULT: OpA=-3, OpB=5, Start at cycle 0 → Busy from cycle 1; cycle 34 HiLoWrite=11, HiOut=FFFFFFFF, LoOut=FFFFFFF1, Done=1.
- DIVU 100/7 → WRITE at cycle 34 with LO=14, HI=2.
- DIV -7/2 → LO=FFFFFFFD, HI=FFFFFFFF.
- DIV 0x80000000/-1 → LO=80000000, HI=0.
- DIV 9/0 → WRITE at cycle 1 with HI=9, LO=FFFFFFFF, DivByZero=1; no ITER cycles.
- MADD: HiIn=0, LoIn=FFFFFFFF, OpA=1, OpB=1 → WRITE at cycle 35 with HI=1, LO=0.
- MSUB: HiIn=0, LoIn=0, OpA=1, OpB=1 → HI=FFFFFFFF, LO=FFFFFFFF.
- Stall during MULTU:
  - HiLoRead=1 from cycle 5 → Stall=1 cycles 5..34 inclusive, 0 at cycle 35.
  - A second Start during Busy is not accepted until IDLE; back-to-back ops both write.
- Rst=0 at cycle 10 of a DIV → Busy=0 and Stall=0 immediately, HiLoWrite never asserted.
- After release, MULT 2*3 → LO=6, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers for the HI/LO multiply/divide sequencer
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MSUB  = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_ACC,
        S_WRITE
    } state_e;

    localparam int ITER_COUNT = 32;
    localparam int HLW_HI = 0;
    localparam int HLW_LO = 1;
    localparam logic [1:0] HLW_BOTH = (2'b1 << HLW_HI) | (2'b1 << HLW_LO);

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_MSUB;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return !(op == OP_MULTU || op == OP_DIVU);
    endfunction

    function automatic logic op_is_acc(input logic [2:0] op);
        return op == OP_MADD || op == OP_MSUB;
    endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// hilo_muldiv_sequencer_if: EX-stage issue and HI/LO write-back bundle
interface hilo_muldiv_sequencer_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [31:0] HiIn;
    logic [31:0] LoIn;
    logic        HiLoRead;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic [1:0]  HiLoWrite;

    modport master (
        output Start, Op, OpA, OpB, HiIn, LoIn, HiLoRead,
        input  Busy, Stall, Done, DivByZero, HiOut, LoOut, HiLoWrite
    );

    modport slave (
        input  Start, Op, OpA, OpB, HiIn, LoIn, HiLoRead,
        output Busy, Stall, Done, DivByZero, HiOut, LoOut, HiLoWrite
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: 64-bit working register with shift-add multiply, restoring divide and sign fix
module muldiv_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        fix,
    input  logic        is_div,
    input  logic        neg_q,
    input  logic        neg_r,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] work,
    output logic [63:0] fixed
);
    logic [31:0] m;
    logic [32:0] r33;
    logic [32:0] sum;
    logic        ge;
    logic [63:0] nxt;

    // one iteration step and the final sign correction of the working register
    always_comb begin
        r33 = is_div ? work[63:31] : {1'b0, work[63:32]};
        sum = is_div ? r33 - {1'b0, m} : r33 + {1'b0, m};
        ge = r33 >= {1'b0, m};
        nxt = is_div ? (ge ? {sum[31:0], work[30:0], 1'b1} : {work[62:0], 1'b0})
                     : (work[0] ? {sum, work[31:1]} : {1'b0, work[63:1]});
        fixed = is_div ? {neg_r ? -work[63:32] : work[63:32], neg_q ? -work[31:0] : work[31:0]}
                       : (neg_q ? -work : work);
    end

    // working register: load magnitudes, iterate, then apply sign fix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            m <= '0;
        end else if (load) begin
            work <= {32'd0, a};
            m <= b;
        end else if (step) begin
            work <= nxt;
        end else if (fix) begin
            work <= fixed;
        end
    end
endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: multi-cycle mul/div FSM owning HI/LO writes and pipeline stall
module hilo_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic Clk,
    input  logic Rst,
    hilo_muldiv_sequencer_if.slave bus
);
    state_e state;
    op_e op_q;
    logic [5:0] cnt;
    logic sa, sb, sgn_in, sgn_q, busy, accept, div0;
    logic [DATA_W-1:0] hi_b, lo_b, hi_q, lo_q, a_mag, b_mag;
    logic done_q, dbz_q;
    logic [1:0] hlw_q;
    logic [63:0] work, fixed, acc;

    // operand magnitudes, issue decode and accumulate result
    always_comb begin
        sgn_in = op_signed(bus.Op);
        a_mag = (sgn_in && bus.OpA[31]) ? -bus.OpA : bus.OpA;
        b_mag = (sgn_in && bus.OpB[31]) ? -bus.OpB : bus.OpB;
        accept = state == S_IDLE && bus.Start && op_legal(bus.Op);
        div0 = op_is_div(bus.Op) && bus.OpB == '0;
        sgn_q = op_signed(op_q);
        acc = op_q == OP_MADD ? {hi_b, lo_b} + work : {hi_b, lo_b} - work;
    end

    assign busy = state != S_IDLE;
    assign bus.Busy = busy;
    assign bus.Stall = busy & (bus.Start | bus.HiLoRead);
    assign bus.Done = done_q;
    assign bus.DivByZero = dbz_q;
    assign bus.HiOut = hi_q;
    assign bus.LoOut = lo_q;
    assign bus.HiLoWrite = hlw_q;

    muldiv_core u_core (
        .clk    (Clk),
        .rst_n  (Rst),
        .load   (accept && !div0),
        .step   (state == S_ITER),
        .fix    (state == S_FIX),
        .is_div (op_is_div(op_q)),
        .neg_q  (sgn_q & (sa ^ sb)),
        .neg_r  (sgn_q & sa),
        .a      (a_mag),
        .b      (b_mag),
        .work   (work),
        .fixed  (fixed)
    );

    // sequencer FSM with registered write-back outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
            op_q <= OP_MULT;
            cnt <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            hi_b <= '0;
            lo_b <= '0;
            hi_q <= '0;
            lo_q <= '0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
            hlw_q <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q <= 1'b0;
            hlw_q <= '0;
            case (state)
                S_IDLE: if (accept) begin
                    op_q <= op_e'(bus.Op);
                    sa <= bus.OpA[31];
                    sb <= bus.OpB[31];
                    hi_b <= bus.HiIn;
                    lo_b <= bus.LoIn;
                    cnt <= '0;
                    if (div0) begin
                        state <= S_WRITE;
                        hi_q <= bus.OpA;
                        lo_q <= DIV0_LO;
                        dbz_q <= 1'b1;
                        done_q <= 1'b1;
                        hlw_q <= HLW_BOTH;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(ITER_COUNT - 1)) state <= S_FIX;
                end
                S_FIX: if (op_is_acc(op_q)) begin
                    state <= S_ACC;
                end else begin
                    state <= S_WRITE;
                    {hi_q, lo_q} <= fixed;
                    done_q <= 1'b1;
                    hlw_q <= HLW_BOTH;
                end
                S_ACC: begin
                    state <= S_WRITE;
                    {hi_q, lo_q} <= acc;
                    done_q <= 1'b1;
                    hlw_q <= HLW_BOTH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer: scoreboard bench with arithmetic reference model
module tb_hilo_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          at;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int cyc = 0;
    int cmp = 0;
    int errs = 0;
    exp_t q[$];
    exp_t me;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    hilo_muldiv_sequencer_if bus();

    hilo_muldiv_sequencer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l, input int e);
        exp_t r;
        longint sa, sb, qq, rr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.dz = 1'b0;
        r.at = e + 33;
        r.hi = '0;
        r.lo = '0;
        case (op)
            OP_MULT:  {r.hi, r.lo} = 64'(sa * sb);
            OP_MULTU: {r.hi, r.lo} = {32'd0, a} * {32'd0, b};
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                    r.dz = 1'b1;
                    r.at = e;
                end else if (op == OP_DIV) begin
                    qq = sa / sb;
                    rr = sa % sb;
                    r.lo = qq[31:0];
                    r.hi = rr[31:0];
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: begin
                p = 64'(sa * sb);
                {r.hi, r.lo} = (op == OP_MADD) ? {h, l} + p : {h, l} - p;
                r.at = e + 34;
            end
        endcase
        return r;
    endfunction

    // monitor: every write-back is matched against the oldest expected result
    always @(negedge Clk) begin
        if (bus.Done || bus.HiLoWrite != 2'b00) begin
            if (q.size() == 0) begin
                cmp++;
                errs++;
                $display("FAIL unexpected_write: HiLoWrite=%b Done=%b with nothing pending (cycle %0d)",
                         bus.HiLoWrite, bus.Done, cyc);
            end else begin
                me = q.pop_front();
                check("hilowrite", {62'd0, bus.HiLoWrite}, 64'd3);
                check("done", {63'd0, bus.Done}, 64'd1);
                check("hi", {32'd0, bus.HiOut}, {32'd0, me.hi});
                check("lo", {32'd0, bus.LoOut}, {32'd0, me.lo});
                check("divbyzero", {63'd0, bus.DivByZero}, {63'd0, me.dz});
                check("write_cycle", 64'(cyc), 64'(me.at));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, output int e);
        int k = 0;
        @(negedge Clk);
        bus.Op = op;
        bus.OpA = a;
        bus.OpB = b;
        bus.HiIn = h;
        bus.LoIn = l;
        bus.Start = 1'b1;
        while (bus.Busy && k < 200) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 200) begin
            cmp++;
            errs++;
            $display("FAIL issue_timeout: Busy=%b after %0d cycles, required 0", bus.Busy, k);
        end
        e = cyc + 1;
        if (op_legal(op)) q.push_back(model(op, a, b, h, l, e));
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.HiIn = $urandom;
        bus.LoIn = $urandom;
        if (!op_legal(op)) check("ignored_op_busy", {63'd0, bus.Busy}, 64'd0);
    endtask

    function automatic logic [31:0] rand_opnd();
        int s = $urandom_range(0, 7);
        return s == 0 ? 32'h8000_0000 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'($urandom_range(0, 20)) : $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e;
        logic [2:0] op;
        logic [31:0] a, b;
        bus.Start = 1'b0;
        bus.Op = '0;
        bus.OpA = '0;
        bus.OpB = '0;
        bus.HiIn = '0;
        bus.LoIn = '0;
        bus.HiLoRead = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_busy", {63'd0, bus.Busy}, 64'd0);
        check("rst_stall", {63'd0, bus.Stall}, 64'd0);
        check("rst_done", {63'd0, bus.Done}, 64'd0);
        check("rst_dbz", {63'd0, bus.DivByZero}, 64'd0);
        check("rst_hilowrite", {62'd0, bus.HiLoWrite}, 64'd0);
        check("rst_hiout", {32'd0, bus.HiOut}, 64'd0);
        check("rst_loout", {32'd0, bus.LoOut}, 64'd0);
        bus.HiLoRead = 1'b0;
        Rst = 1'b1;

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, e);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, e);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, e);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, e);
        issue(OP_DIV, 32'd9, 32'd0, 32'd0, 32'd0, e);
        issue(OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, e);
        issue(OP_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, e);
        issue(3'b110, 32'd3, 32'd4, 32'd0, 32'd0, e);
        issue(3'b111, 32'd3, 32'd4, 32'd0, 32'd0, e);

        issue(OP_MULTU, $urandom, $urandom, 32'd0, 32'd0, e);
        repeat (5) @(negedge Clk);
        for (int n = 5; n <= 35; n++) begin
            bus.HiLoRead = 1'b1;
            #1;
            check($sformatf("stall_c%0d", n), {63'd0, bus.Stall}, {63'd0, n <= 34});
            @(negedge Clk);
        end
        bus.HiLoRead = 1'b0;

        issue(OP_MULTU, $urandom, $urandom, 32'd0, 32'd0, e);
        issue(OP_DIVU, $urandom, 32'($urandom_range(1, 1000)), 32'd0, 32'd0, e);

        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, e);
        repeat (10) @(negedge Clk);
        bus.HiLoRead = 1'b1;
        #2;
        Rst = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.Busy}, 64'd0);
        check("abort_stall", {63'd0, bus.Stall}, 64'd0);
        q.delete();
        repeat (3) begin
            @(negedge Clk);
            check("abort_hilowrite", {62'd0, bus.HiLoWrite}, 64'd0);
        end
        bus.HiLoRead = 1'b0;
        Rst = 1'b1;
        issue(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd0, e);

        repeat (40) begin
            op = 3'($urandom_range(0, 7));
            a = rand_opnd();
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : rand_opnd();
            issue(op, a, b, $urandom, $urandom, e);
        end

        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        check("pending_results", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
